// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg: shared UART types and constants                       Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_BYTE_W      = 8;
  localparam int BAUD_DIV_DEFAULT = 104;  // 12 MHz / 115200

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } uart_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin picker, first request at or above ptr
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 found
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = IW'((int'(ptr) + i) % N);
      if (!found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter: round-robin sharing of one UART transmitter      Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           baud_tick,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_byte,
  output logic                           tx_send,
  input  logic                           tx_done,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [WD_W-1:0]  c_wd_limit = WD_W'(TIMEOUT_TICKS);
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  uart_tx_state_t r_state, w_state_nxt;
  logic [ID_W-1:0]        r_ptr, w_ptr_nxt;
  logic [WD_W-1:0]        r_wd_cnt, w_wd_nxt;
  logic [GAP_W-1:0]       r_gap_cnt, w_gap_nxt;
  logic [NUM_REQ-1:0]     w_ready_nxt;
  logic [UART_BYTE_W-1:0] w_byte_nxt;
  logic                   w_send_nxt;
  logic [ID_W-1:0]        w_gid_nxt;
  logic                   w_terr_nxt;

  logic [NUM_REQ-1:0]     w_grant;
  logic                   w_found;
  logic [ID_W-1:0]        w_gidx;
  logic [UART_BYTE_W-1:0] w_gdata;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .found (w_found)
  );

  always_comb begin
    w_gidx  = '0;
    w_gdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx  = ID_W'(i);
        w_gdata = req_data[UART_BYTE_W*i +: UART_BYTE_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_wd_nxt    = r_wd_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_ready_nxt = '0;
    w_byte_nxt  = tx_byte;
    w_send_nxt  = 1'b0;
    w_gid_nxt   = grant_id;
    w_terr_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A done flag still high from the last frame blocks the next grant.
        if (w_found && !tx_done) begin
          w_ready_nxt = w_grant;
          w_byte_nxt  = w_gdata;
          w_gid_nxt   = w_gidx;
          w_ptr_nxt   = (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + ID_W'(1);
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_wd_cnt == c_wd_limit) begin
          w_terr_nxt  = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else begin
          w_send_nxt = 1'b1;
          if (baud_tick) w_wd_nxt = r_wd_cnt + WD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!tx_done) begin
          w_state_nxt = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (baud_tick) begin
          if (r_gap_cnt == c_gap_last) w_state_nxt = ST_IDLE;
          else                         w_gap_nxt   = r_gap_cnt + GAP_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt != r_state) begin
      w_wd_nxt  = '0;
      w_gap_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_wd_cnt    <= '0;
      r_gap_cnt   <= '0;
      req_ready   <= '0;
      tx_byte     <= '0;
      tx_send     <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_wd_cnt    <= w_wd_nxt;
      r_gap_cnt   <= w_gap_nxt;
      req_ready   <= w_ready_nxt;
      tx_byte     <= w_byte_nxt;
      tx_send     <= w_send_nxt;
      grant_id    <= w_gid_nxt;
      timeout_err <= w_terr_nxt;
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter: scoreboard bench for the shared UART transmitter arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } gexp_t;

  logic        clk;
  logic        rst;
  logic        baud_tick;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .GAP_TICKS     (1),
    .TIMEOUT_TICKS (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_byte     (tx_byte),
    .tx_send     (tx_send),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  gexp_t      exp_g[$];
  logic [7:0] exp_s[$];
  int         exp_to = 0;

  logic [7:0] src_mem[4][8];
  int         src_rd[4];
  int         src_wr[4];

  logic model_en   = 1'b1;
  int   hold_ticks = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int id, input logic [7:0] data);
    src_mem[id][src_wr[id] % 8] = data;
    src_wr[id]++;
  endtask

  task automatic expect_grant(input logic [1:0] id, input logic [7:0] data);
    exp_g.push_back('{id: id, data: data});
    exp_s.push_back(data);
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < 4; i++) if (src_rd[i] < src_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (n < 3000 && !(exp_g.size() == 0 && exp_s.size() == 0 && !busy &&
                         tx_done == 1'b0 && src_empty())) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_completion"}, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle baud pulse every 8 clocks, driven just after the rising edge.
  initial begin
    int bcnt;
    bcnt      = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (bcnt == 7);
      bcnt      = (bcnt + 1) % 8;
    end
  end

  // Requesters: each holds its head byte valid until accepted.
  initial begin
    for (int i = 0; i < 4; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && src_rd[i] < src_wr[i]) src_rd[i]++;
        req_valid[i]        = (src_rd[i] < src_wr[i]);
        req_data[8*i +: 8]  = src_mem[i][src_rd[i] % 8];
      end
    end
  end

  // Transmitter model: done rises 10 ticks after send, falls hold_ticks later.
  initial begin
    logic mprev;
    int   n;
    tx_done = 1'b0;
    mprev   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_send && !mprev && model_en) begin
        n = 0;
        while (n < 10) begin
          @(negedge clk);
          if (baud_tick) n++;
        end
        #2 tx_done = 1'b1;
        n = 0;
        while (n < hold_ticks) begin
          @(negedge clk);
          if (baud_tick) n++;
        end
        #2 tx_done = 1'b0;
      end
      mprev = tx_send;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant, send or abort.
  initial begin
    gexp_t g;
    logic  prev_send, prev_done, prev_busy, prev_tick, prev_rst;
    logic [3:0] prev_ready;
    int    ticks, d1, d2;
    prev_send = 0; prev_done = 0; prev_busy = 0; prev_tick = 0; prev_rst = 1;
    prev_ready = '0; ticks = 0; d1 = 0; d2 = 0;
    forever begin
      @(negedge clk);
      d2 = d1;
      d1 = ticks;
      if (!rst && req_ready != '0) begin
        if (exp_g.size() == 0) begin
          chk("grant_unexpected", 32'(req_ready), 32'd0);
        end else begin
          g = exp_g.pop_front();
          chk("req_ready_onehot", 32'(req_ready), 32'(4'b0001 << g.id));
          chk("grant_id", 32'(grant_id), 32'(g.id));
          chk("tx_byte_latch", 32'(tx_byte), 32'(g.data));
          chk("grant_after_done_low", 32'(prev_done), 32'd0);
        end
        ticks = baud_tick ? 1 : 0;
      end else if (baud_tick) begin
        ticks++;
      end
      if (tx_send && !prev_send) begin
        if (exp_s.size() == 0) begin
          chk("send_unexpected", 32'(tx_byte), 32'hFFFF);
        end else begin
          chk("tx_byte_at_send", 32'(tx_byte), 32'(exp_s.pop_front()));
          chk("send_one_cycle_after_ready", 32'(prev_ready != '0), 32'd1);
        end
      end
      if (timeout_err) begin
        chk("timeout_expected", 32'(exp_to > 0), 32'd1);
        if (exp_to > 0) exp_to--;
        chk("timeout_tick_count", 32'(d2), 32'd16);
        chk("timeout_send_low", 32'(tx_send), 32'd0);
      end
      if (prev_busy && !busy && !prev_rst) begin
        chk("busy_fall_on_gap_tick", 32'(prev_tick), 32'd1);
      end
      prev_send  = tx_send;
      prev_done  = tx_done;
      prev_busy  = busy;
      prev_tick  = baud_tick;
      prev_rst   = rst;
      prev_ready = req_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got %0t limit 200000", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_tx_byte", 32'(tx_byte), 32'd0);
    chk("reset_tx_send", 32'(tx_send), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_timeout_err", 32'(timeout_err), 32'd0);

    // Single request from requester 2.
    expect_grant(2'd2, 8'hA5);
    load(2, 8'hA5);
    wait_idle("single");

    // Wrap: grant 3 alone (pointer -> 0), then 1 and 3 together -> 1 first.
    expect_grant(2'd3, 8'h31);
    load(3, 8'h31);
    wait_idle("wrap_pre");
    expect_grant(2'd1, 8'h41);
    expect_grant(2'd3, 8'h43);
    load(1, 8'h41);
    load(3, 8'h43);
    wait_idle("wrap");

    // Fairness with all four valid continuously.
    expect_grant(2'd0, 8'h10);
    expect_grant(2'd1, 8'h11);
    expect_grant(2'd2, 8'h12);
    expect_grant(2'd3, 8'h13);
    expect_grant(2'd0, 8'h10);
    load(0, 8'h10); load(0, 8'h10);
    load(1, 8'h11); load(2, 8'h12); load(3, 8'h13);
    wait_idle("round_robin");

    // Timeout: pointer is 1; requester 1 aborts, requester 2 follows.
    model_en = 1'b0;
    exp_to   = 1;
    expect_grant(2'd1, 8'h55);
    expect_grant(2'd2, 8'h66);
    load(1, 8'h55);
    load(2, 8'h66);
    n = 0;
    while (n < 600 && !timeout_err) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_seen", 32'(n < 600), 32'd1);
    model_en = 1'b1;
    wait_idle("timeout");
    chk("timeout_consumed", 32'(exp_to), 32'd0);

    // Stale done: three extra ticks of tx_done before requester 2 is served.
    hold_ticks = 4;
    expect_grant(2'd3, 8'h77);
    expect_grant(2'd2, 8'h88);
    load(3, 8'h77);
    load(2, 8'h88);
    wait_idle("stale_done");
    hold_ticks = 1;

    // Reset during SEND discards the byte and clears the pointer.
    model_en = 1'b0;
    expect_grant(2'd1, 8'h99);
    load(1, 8'h99);
    n = 0;
    while (n < 200 && !tx_send) begin
      @(negedge clk);
      n++;
    end
    chk("reset_frame_send_seen", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_tx_send", 32'(tx_send), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_grant_id", 32'(grant_id), 32'd0);
    chk("midreset_req_ready", 32'(req_ready), 32'd0);
    model_en = 1'b1;
    expect_grant(2'd0, 8'hB0);
    expect_grant(2'd2, 8'hB2);
    load(0, 8'hB0);
    load(2, 8'hB2);
    wait_idle("after_reset");

    chk("grant_queue_empty", 32'(exp_g.size()), 32'd0);
    chk("send_queue_empty", 32'(exp_s.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
